// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - iterative shift-add multiplier, full-width product, signed/unsigned per operation
module mult_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     n_in,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;     // upper W+1 bits: partial sum, lower W bits: remaining multiplier bits
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   m_abs;
  logic [WIDTH-1:0]   n_abs;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_low;

  assign busy = (state != IDLE);

  // Operand magnitudes, the conditional add into the upper half, and the final low product word
  always_comb begin
    m_abs     = (signed_mode && m_in[WIDTH-1]) ? -m_in : m_in;
    n_abs     = (signed_mode && n_in[WIDTH-1]) ? -n_in : n_in;
    upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    acc_low   = acc[2*WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: one RUN cycle per multiplier bit, then a single FIX cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, shift-add in RUN, sign-fix and publish in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= m_abs;
            acc   <= {{(WIDTH+1){1'b0}}, n_abs};
            cnt   <= '0;
            neg   <= signed_mode & (m_in[WIDTH-1] ^ n_in[WIDTH-1]);
          end
        end
        RUN: begin
          acc <= {1'b0, upper_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          prod <= neg ? -acc_low : acc_low;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// tb/tb_mult_seq_param.sv - directed self-checking bench for mult_seq_param
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] m_in;
  logic [15:0] n_in;
  logic [31:0] prod;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  mult_seq_param #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .m_in        (m_in),
    .n_in        (n_in),
    .prod        (prod),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Launch one operation, hold start for 'hold' edges, then watch 'ncyc' cycles.
  task automatic run_op(input logic [15:0] m, input logic [15:0] n, input logic sm,
                        input int hold, input int ncyc,
                        output logic [31:0] p, output int busy_cnt, output int done_cnt,
                        output int done_at, output int overlap);
    busy_cnt = 0; done_cnt = 0; done_at = 0; overlap = 0; p = '0;
    m_in = m; n_in = n; signed_mode = sm; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == hold) start = 1'b0;
      if (busy) busy_cnt++;
      if (done && busy) overlap++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c;
          p = prod;
        end
      end
    end
  endtask

  logic [31:0] p, p1, p2;
  int bc, dc, da, ov, d1, d2;

  initial begin
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; m_in = '0; n_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_prod", prod, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Start held for three edges: only one operation may run
    run_op(16'h00AB, 16'h00CD, 1'b0, 3, 40, p, bc, dc, da, ov);
    check("t1_prod", p, 32'h0000_88EF);
    check("t1_busy_cycles", bc, 17);
    check("t1_done_count", dc, 1);
    check("t1_done_latency", da, 18);
    check("t1_done_busy_overlap", ov, 0);

    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1, 25, p, bc, dc, da, ov);
    check("t2_unsigned_max", p, 32'hFFFE_0001);
    check("t2_u_done_count", dc, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 25, p, bc, dc, da, ov);
    check("t2_signed_m1_m1", p, 32'h0000_0001);

    run_op(16'hFFFD, 16'h0005, 1'b1, 1, 25, p, bc, dc, da, ov);
    check("t3_signed_m3_5", p, 32'hFFFF_FFF1);
    run_op(16'h8000, 16'h8000, 1'b1, 1, 25, p, bc, dc, da, ov);
    check("t3_signed_minmin", p, 32'h4000_0000);
    check("t3_prod_held", prod, 32'h4000_0000);

    // Reset five cycles into an operation
    m_in = 16'h1234; n_in = 16'h5678; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    check("t5_abort_prod", prod, 0);
    dc = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("t5_no_done_after_abort", dc, 0);
    run_op(16'h1234, 16'h5678, 1'b0, 1, 25, p, bc, dc, da, ov);
    check("t5_restart_prod", p, 32'h0626_0060);

    // Start held high continuously: back-to-back operations
    m_in = 16'd7; n_in = 16'd6; signed_mode = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0; p1 = '0; p2 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) begin
          d1 = c; p1 = prod; m_in = 16'h0000; n_in = 16'h1234;
        end else if (d2 == 0) begin
          d2 = c; p2 = prod; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("t4_first_prod", p1, 32'h0000_002A);
    check("t4_second_prod", p2, 32'h0000_0000);
    check("t4_first_latency", d1, 18);
    check("t4_done_spacing", d2 - d1, 18);

    // Operand changes and start toggling while busy are ignored
    m_in = 16'h0101; n_in = 16'h0003; signed_mode = 1'b0; start = 1'b1;
    dc = 0; da = 0; p = '0; ov = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        m_in = 16'hFFFF; n_in = 16'h8000; signed_mode = 1'b1;
      end
      start = (c < 15) ? ~start : 1'b0;
      if (done && busy) ov++;
      if (done) begin
        dc++;
        if (da == 0) begin
          da = c; p = prod;
        end
      end
    end
    check("t6_prod_latched", p, 32'h0000_0303);
    check("t6_done_count", dc, 1);
    check("t6_done_latency", da, 18);
    check("t6_done_busy_overlap", ov, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
